sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- ADDR_WIDTH, 9, word address width.
- DATA_WIDTH, 32, data width.
- NUM_WMASKS, 4, byte-lane write-enable count.
- MAX_BURST, 4, maximum consecutive grants while the other requester waits.

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock; one clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high.
- req0 / req1, in, 1, requester n wants the RW port.
- we0 / we1, in, 1, 1 = write, 0 = read.
- wmask0_i / wmask1_i, in, NUM_WMASKS, byte enables for a write.
- addr0_i / addr1_i, in, ADDR_WIDTH, word address.
- wdata0 / wdata1, in, DATA_WIDTH, write data.
- gnt0 / gnt1, out, 1, request accepted this cycle.
- rvalid0 / rvalid1, out, 1, read data valid for requester n.
- rdata0 / rdata1, out, DATA_WIDTH, read data.
- sram_csb0, out, 1, macro chip select, active low.
- sram_web0, out, 1, macro write enable, active low.
- sram_wmask0, out, NUM_WMASKS, macro byte mask.
- sram_addr0, out, ADDR_WIDTH, macro address.
- sram_din0, out, DATA_WIDTH, macro write data.
- sram_dout0, in, DATA_WIDTH, macro read data.

Function
REQ-003 gnt0/gnt1 SHALL be combinational from the req inputs and the arbiter state, one-hot or zero, with at most one access per cycle.
REQ-004 In a grant cycle, the granted requester's we/wmask/addr/wdata SHALL drive the sram_* outputs combinationally, with sram_csb0=0 and sram_web0=~we.
REQ-005 In a non-grant cycle, sram_csb0 SHALL be 1, sram_web0 SHALL be 1, and sram_wmask0, sram_addr0 and sram_din0 SHALL be 0.
REQ-006 The arbiter FSM SHALL have states IDLE, OWN0 and OWN1:
- IDLE: sole requester wins; if both request, the priority pointer wins.
- OWNn: n keeps the grant while reqn=1 and the burst count is below MAX_BURST, or while the other requester is idle.
- OWNn moves to OWNm when reqn drops and reqm=1, or when the burst count reaches MAX_BURST and reqm=1.
- OWNn returns to IDLE when neither requester requests.
REQ-007 The burst counter SHALL be ceil(log2(MAX_BURST+1)) bits wide:
- It SHALL reset to 0 on every ownership change.
- It SHALL increment per grant and saturate at MAX_BURST.
- While the other requester is idle, it SHALL NOT force a switch.
REQ-008 The priority pointer SHALL toggle to the non-winner after every contested arbitration, giving round-robin.
REQ-009 Read latency SHALL be 2 cycles:
- A read granted in cycle N is sampled by the macro at the edge ending N.
- sram_dout0 is registered at the edge ending N+1.
- rvalidn=1 and rdatan valid SHALL hold for exactly one cycle in N+2.
REQ-010 Writes SHALL produce no rvalid; a write is complete when granted.
REQ-011 Back-to-back reads SHALL be fully pipelined at one per cycle, with rvalid order equal to grant order; a 2-deep tag shift register SHALL record the owner of each in-flight read.
REQ-012 A read granted the cycle after a write to the same address SHALL return the new data; the arbiter SHALL NOT insert stalls.
REQ-013 rdata0/rdata1 SHALL hold their last value when rvalid is low.

Reset
REQ-014 When reset=1, the block SHALL:
- force the state to IDLE, the pointer to requester 0 and the burst count to 0;
- drive gnt0=gnt1=0 and sram_csb0=1;
- clear the in-flight tags, so rvalid0=rvalid1=0 from the next cycle;
- clear rdata0/rdata1 to 0.
REQ-015 Reads in flight when reset asserts SHALL never produce rvalid.

Structure
REQ-016 Package sram_ctrl_pkg SHALL hold the width parameters, the MAX_BURST default and the FSM state enum.
REQ-017 Sub-module sram_rr_arb SHALL contain the FSM, the pointer and the burst counter; the top level SHALL hold the mux, the read pipeline and the rdata registers.

Verification
REQ-018 The bench SHALL cover these directed scenarios, running against the behavioural 32x512 macro:
- After reset, req0 writes 0xDEADBEEF to address 5 with mask 0xF, then reads address 5 -> gnt0 in both cycles; rvalid0 two cycles after the read grant with rdata0=0xDEADBEEF.
- req0 and req1 both held high for 12 cycles, all reads -> grants run 0,0,0,0,1,1,1,1,0,0,0,0; every rvalid is routed to the correct requester in order.
- req1 alone, 10 consecutive reads of addresses 0..9 -> gnt1 every cycle with no forced switch; 10 rvalid1 pulses in address order.
- Byte write with mask 0x2 and data 0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
- reset asserted in the cycle after a read grant -> no rvalid in the following 3 cycles; state IDLE; sram_csb0=1.
- Simultaneous first requests after reset -> gnt0 wins; the next contested arbitration after a drop to IDLE -> gnt1 wins.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared widths, burst default and arbiter state encoding for the SRAM port arbiter.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_ADDR_WIDTH = 9;
    localparam int unsigned SRAM_DATA_WIDTH = 32;
    localparam int unsigned SRAM_NUM_WMASKS = 4;
    localparam int unsigned SRAM_MAX_BURST  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-requester round-robin arbiter with burst limiting. Grants are combinational
// from the requests and the registered ownership state.
module sram_rr_arb
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned MAX_BURST = SRAM_MAX_BURST
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    arb_state_e      r_state;
    arb_state_e      w_state_nxt;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
    logic            r_ptr;      // 0: requester 0 wins the next contested IDLE arbitration
    logic            w_ptr_nxt;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_both;
    logic            w_burst_done;

    assign w_both       = i_req0 & i_req1;
    assign w_burst_done = (r_cnt >= CntW'(MAX_BURST));

    // Grant decision, next ownership, burst count and priority pointer.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;

        unique case (r_state)
            StIdle: begin
                if (w_both) begin
                    w_gnt0 = ~r_ptr;
                    w_gnt1 = r_ptr;
                end else begin
                    w_gnt0 = i_req0;
                    w_gnt1 = i_req1;
                end
            end
            StOwn0: begin
                // Owner keeps the port until it drops or the burst is spent with a waiter.
                if (i_req0 && (!w_burst_done || !i_req1)) begin
                    w_gnt0 = 1'b1;
                end else if (i_req1) begin
                    w_gnt1 = 1'b1;
                end
            end
            StOwn1: begin
                if (i_req1 && (!w_burst_done || !i_req0)) begin
                    w_gnt1 = 1'b1;
                end else if (i_req0) begin
                    w_gnt0 = 1'b1;
                end
            end
            default: begin
                w_gnt0 = 1'b0;
                w_gnt1 = 1'b0;
            end
        endcase

        if (w_gnt0) begin
            w_state_nxt = StOwn0;
        end else if (w_gnt1) begin
            w_state_nxt = StOwn1;
        end else begin
            w_state_nxt = StIdle;
        end

        // Count restarts on an ownership change; the first grant of a tenure counts as one.
        if (w_gnt0 || w_gnt1) begin
            if (w_state_nxt != r_state) begin
                w_cnt_nxt = CntW'(1);
            end else if (!w_burst_done) begin
                w_cnt_nxt = r_cnt + CntW'(1);
            end
        end else begin
            w_cnt_nxt = '0;
        end

        // Any contested cycle hands priority to whoever lost it.
        if (w_both) begin
            w_ptr_nxt = w_gnt0;
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_ptr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign o_gnt0 = w_gnt0 & ~reset;
    assign o_gnt1 = w_gnt1 & ~reset;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM RW port between two requesters: grant mux, 2-cycle read pipeline
// with owner tags, and per-requester read data registers.
module sram_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int unsigned NUM_WMASKS = SRAM_NUM_WMASKS,
    parameter int unsigned MAX_BURST  = SRAM_MAX_BURST
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [NUM_WMASKS-1:0] wmask0_i,
    input  logic [NUM_WMASKS-1:0] wmask1_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_rd_issue;
    logic                  r_tag1_vld;  // read sampled by the macro last edge
    logic                  r_tag1_id;
    logic                  r_tag2_vld;  // read whose data sits in the rdata registers
    logic                  r_tag2_id;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    sram_rr_arb #(
        .MAX_BURST(MAX_BURST)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .i_req0(req0),
        .i_req1(req1),
        .o_gnt0(w_gnt0),
        .o_gnt1(w_gnt1)
    );

    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    assign w_rd_issue = (w_gnt0 & ~we0) | (w_gnt1 & ~we1);

    // Route the granted requester onto the macro port; park it quiet otherwise.
    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (w_gnt0) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~we0;
            sram_wmask0 = wmask0_i;
            sram_addr0  = addr0_i;
            sram_din0   = wdata0;
        end else if (w_gnt1) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~we1;
            sram_wmask0 = wmask1_i;
            sram_addr0  = addr1_i;
            sram_din0   = wdata1;
        end
    end

    // Owner-tag pipeline and read data capture; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag1_vld <= 1'b0;
            r_tag1_id  <= 1'b0;
            r_tag2_vld <= 1'b0;
            r_tag2_id  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_tag1_vld <= w_rd_issue;
            r_tag1_id  <= w_gnt1;
            r_tag2_vld <= r_tag1_vld;
            r_tag2_id  <= r_tag1_id;
            if (r_tag1_vld && !r_tag1_id) begin
                r_rdata0 <= sram_dout0;
            end
            if (r_tag1_vld && r_tag1_id) begin
                r_rdata1 <= sram_dout0;
            end
        end
    end

    assign rvalid0 = r_tag2_vld & ~r_tag2_id;
    assign rvalid1 = r_tag2_vld & r_tag2_id;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 32x512 macro and a read scoreboard.
module tb_sram_port_arbiter;
    import sram_ctrl_pkg::*;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [MW-1:0] wmask0_i, wmask1_i;
    logic [AW-1:0] addr0_i, addr1_i;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          sram_csb0, sram_web0;
    logic [MW-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    bit          mon_e0, mon_e1;
    bit          mon_on = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] mem   [512];
    logic [31:0] model [512];

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_WMASKS(MW),
        .MAX_BURST (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .wmask0_i   (wmask0_i),
        .wmask1_i   (wmask1_i),
        .addr0_i    (addr0_i),
        .addr1_i    (addr1_i),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_wmask0(sram_wmask0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
    );

    // Behavioural macro: inputs sampled at the rising edge, read data available the next cycle.
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int i = 0; i < MW; i++) begin
                    if (sram_wmask0[i]) mem[sram_addr0][8*i +: 8] = sram_din0[8*i +: 8];
                end
            end else begin
                sram_dout0 <= mem[sram_addr0];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_read(input int id, input logic [31:0] data);
        sb.push_back('{id: id, data: data, due: cyc + 2});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        wmask0_i = '0; wmask1_i = '0; addr0_i = '0; addr1_i = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        quiet();
        repeat (n) next_cycle();
    endtask

    // Read-return monitor: rvalid must match the scoreboard head exactly when it falls due.
    always @(negedge clk) begin
        if (mon_on) begin
            mon_e0 = 1'b0;
            mon_e1 = 1'b0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                if (mon_e.id == 0) begin
                    mon_e0 = 1'b1;
                    chk("rdata0", rdata0, mon_e.data);
                end else begin
                    mon_e1 = 1'b1;
                    chk("rdata1", rdata1, mon_e.data);
                end
            end
            chk("rvalid0", rvalid0, mon_e0);
            chk("rvalid1", rvalid1, mon_e1);
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]   = 32'hC0DE_0000 | i;
            model[i] = 32'hC0DE_0000 | i;
        end

        // Reset with both requests high: nothing may be granted.
        quiet();
        reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        next_cycle();
        mon_on = 1'b1;
        @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_csb", sram_csb0, 1);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_state", dut.u_arb.r_state, StIdle);
        next_cycle();
        reset = 1'b0;
        quiet();

        // Write then read back address 5.
        req0 = 1'b1; we0 = 1'b1; addr0_i = 9'd5; wdata0 = 32'hDEADBEEF; wmask0_i = 4'hF;
        @(negedge clk);
        chk("s1_wr_gnt0", gnt0, 1);
        chk("s1_wr_gnt1", gnt1, 0);
        chk("s1_wr_csb", sram_csb0, 0);
        chk("s1_wr_web", sram_web0, 0);
        chk("s1_wr_addr", sram_addr0, 5);
        chk("s1_wr_din", sram_din0, 32'hDEADBEEF);
        chk("s1_wr_mask", sram_wmask0, 4'hF);
        model[5] = 32'hDEADBEEF;
        next_cycle();
        we0 = 1'b0;
        @(negedge clk);
        chk("s1_rd_gnt0", gnt0, 1);
        chk("s1_rd_web", sram_web0, 1);
        expect_read(0, 32'hDEADBEEF);
        next_cycle();
        quiet();
        @(negedge clk);
        chk("s1_idle_csb", sram_csb0, 1);
        chk("s1_idle_web", sram_web0, 1);
        chk("s1_idle_addr", sram_addr0, 0);
        chk("s1_idle_din", sram_din0, 0);
        chk("s1_idle_mask", sram_wmask0, 0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("s1_hold_rdata0", rdata0, 32'hDEADBEEF);
        next_cycle();
        idle(2);

        // Both requesters reading continuously: bursts of four, alternating.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
            addr0_i = AW'(16 + i);
            addr1_i = AW'(32 + i);
            @(negedge clk);
            chk($sformatf("s2_gnt0_%0d", i), gnt0, ((i / 4) % 2) == 0);
            chk($sformatf("s2_gnt1_%0d", i), gnt1, ((i / 4) % 2) == 1);
            if (((i / 4) % 2) == 0) expect_read(0, model[16 + i]);
            else                    expect_read(1, model[32 + i]);
            next_cycle();
        end
        idle(4);

        // Lone requester 1 is never forced off the port.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req1 = 1'b1; we1 = 1'b0; addr1_i = AW'(i);
            @(negedge clk);
            chk($sformatf("s3_gnt1_%0d", i), gnt1, 1);
            chk($sformatf("s3_gnt0_%0d", i), gnt0, 0);
            expect_read(1, model[i]);
            next_cycle();
        end
        idle(4);

        // Byte-lane write followed immediately by a read of the same word.
        req0 = 1'b1; we0 = 1'b1; addr0_i = 9'd40; wdata0 = 32'h11223344; wmask0_i = 4'hF;
        @(negedge clk);
        chk("s4_wr1_gnt0", gnt0, 1);
        next_cycle();
        wdata0 = 32'h0000AB00; wmask0_i = 4'h2;
        @(negedge clk);
        chk("s4_wr2_gnt0", gnt0, 1);
        chk("s4_wr2_mask", sram_wmask0, 4'h2);
        next_cycle();
        we0 = 1'b0; wmask0_i = 4'h0;
        @(negedge clk);
        chk("s4_rd_gnt0", gnt0, 1);
        expect_read(0, 32'h1122AB44);
        next_cycle();
        idle(4);

        // Reset the cycle after a read grant: the read must vanish.
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0_i = 9'd5;
        @(negedge clk);
        chk("s5_rd_gnt0", gnt0, 1);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("s5_rst_gnt0", gnt0, 0);
        chk("s5_rst_csb", sram_csb0, 1);
        next_cycle();
        reset = 1'b0;
        quiet();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("s5_rvalid0_%0d", i), rvalid0, 0);
            chk($sformatf("s5_rvalid1_%0d", i), rvalid1, 0);
            chk($sformatf("s5_state_%0d", i), dut.u_arb.r_state, StIdle);
            chk($sformatf("s5_csb_%0d", i), sram_csb0, 1);
            next_cycle();
        end

        // Contested IDLE arbitration alternates across a drop to IDLE.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr0_i = 9'd100; addr1_i = 9'd200;
        @(negedge clk);
        chk("s6_first_gnt0", gnt0, 1);
        chk("s6_first_gnt1", gnt1, 0);
        expect_read(0, model[100]);
        next_cycle();
        quiet();
        @(negedge clk);
        chk("s6_gap_gnt0", gnt0, 0);
        chk("s6_gap_gnt1", gnt1, 0);
        next_cycle();
        req0 = 1'b1; req1 = 1'b1; addr0_i = 9'd100; addr1_i = 9'd200;
        @(negedge clk);
        chk("s6_second_gnt0", gnt0, 0);
        chk("s6_second_gnt1", gnt1, 1);
        expect_read(1, model[200]);
        next_cycle();
        idle(4);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
